// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-port memory between instruction fetch and data access.
// Data wins ties; a streak limit guarantees that fetch still makes progress.
module mem_port_arbiter #(
    parameter int unsigned ADDR_W        = 32,
    parameter int unsigned DATA_W        = 32,
    parameter int unsigned LATENCY       = 2,
    parameter int unsigned MAX_DM_STREAK = 4
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    input  logic              if_flush,
    input  logic              dm_req,
    input  logic              dm_we,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [DATA_W-1:0] dm_wdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_valid,
    output logic [DATA_W-1:0] dm_rdata,
    output logic              dm_valid,
    output logic              if_stall,
    output logic              dm_stall
);

    typedef enum logic [1:0] {StIdle, StBusyIf, StBusyDm} state_e;

    localparam logic [3:0] CntInit   = 4'(LATENCY - 1);
    localparam logic [3:0] MaxStreak = 4'(MAX_DM_STREAK);

    state_e            r_state, w_state_nxt;
    logic [3:0]        r_cnt, w_cnt_nxt;
    logic [3:0]        r_streak, w_streak_nxt;
    logic              r_flush, w_flush_nxt;
    logic              r_mem_en, w_mem_en_nxt;
    logic              r_mem_we, w_mem_we_nxt;
    logic [ADDR_W-1:0] r_mem_addr, w_mem_addr_nxt;
    logic [DATA_W-1:0] r_mem_wdata, w_mem_wdata_nxt;
    logic [DATA_W-1:0] r_if_rdata, w_if_rdata_nxt;
    logic              r_if_valid, w_if_valid_nxt;
    logic [DATA_W-1:0] r_dm_rdata, w_dm_rdata_nxt;
    logic              r_dm_valid, w_dm_valid_nxt;
    logic              w_grant_dm, w_grant_if;

    assign w_grant_dm = dm_req && (!if_req || (r_streak < MaxStreak));
    assign w_grant_if = !w_grant_dm && if_req && !if_flush;

    always_comb begin
        w_state_nxt     = r_state;
        w_cnt_nxt       = r_cnt;
        w_streak_nxt    = r_streak;
        w_flush_nxt     = r_flush;
        w_mem_en_nxt    = r_mem_en;
        w_mem_we_nxt    = r_mem_we;
        w_mem_addr_nxt  = r_mem_addr;
        w_mem_wdata_nxt = r_mem_wdata;
        w_if_rdata_nxt  = r_if_rdata;
        w_if_valid_nxt  = 1'b0;
        w_dm_rdata_nxt  = r_dm_rdata;
        w_dm_valid_nxt  = 1'b0;
        unique case (r_state)
            StIdle: begin
                w_flush_nxt = 1'b0;
                if (w_grant_dm) begin
                    w_state_nxt     = StBusyDm;
                    w_cnt_nxt       = CntInit;
                    w_mem_en_nxt    = 1'b1;
                    w_mem_we_nxt    = dm_we;
                    w_mem_addr_nxt  = dm_addr;
                    w_mem_wdata_nxt = dm_wdata;
                    if (!if_req) begin
                        w_streak_nxt = 4'd0;
                    end else if (r_streak != 4'hF) begin
                        w_streak_nxt = r_streak + 4'd1;
                    end
                end else if (w_grant_if) begin
                    w_state_nxt    = StBusyIf;
                    w_cnt_nxt      = CntInit;
                    w_mem_en_nxt   = 1'b1;
                    w_mem_we_nxt   = 1'b0;
                    w_mem_addr_nxt = if_addr;
                    w_streak_nxt   = 4'd0;
                end
            end
            StBusyIf: begin
                if (if_flush) begin
                    w_flush_nxt = 1'b1;
                end
                if (r_cnt != 4'd0) begin
                    w_cnt_nxt = r_cnt - 4'd1;
                end else begin
                    w_state_nxt  = StIdle;
                    w_mem_en_nxt = 1'b0;
                    w_mem_we_nxt = 1'b0;
                    w_flush_nxt  = 1'b0;
                    // A flush seen in the final busy cycle also kills the result.
                    if (!r_flush && !if_flush) begin
                        w_if_valid_nxt = 1'b1;
                        w_if_rdata_nxt = mem_rdata;
                    end
                end
            end
            StBusyDm: begin
                if (r_cnt != 4'd0) begin
                    w_cnt_nxt = r_cnt - 4'd1;
                end else begin
                    w_state_nxt    = StIdle;
                    w_mem_en_nxt   = 1'b0;
                    w_mem_we_nxt   = 1'b0;
                    w_dm_valid_nxt = 1'b1;
                    if (!r_mem_we) begin
                        w_dm_rdata_nxt = mem_rdata;
                    end
                end
            end
            default: begin
                w_state_nxt  = StIdle;
                w_mem_en_nxt = 1'b0;
                w_mem_we_nxt = 1'b0;
            end
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_state     <= StIdle;
            r_cnt       <= 4'd0;
            r_streak    <= 4'd0;
            r_flush     <= 1'b0;
            r_mem_en    <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_if_rdata  <= '0;
            r_if_valid  <= 1'b0;
            r_dm_rdata  <= '0;
            r_dm_valid  <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_streak    <= w_streak_nxt;
            r_flush     <= w_flush_nxt;
            r_mem_en    <= w_mem_en_nxt;
            r_mem_we    <= w_mem_we_nxt;
            r_mem_addr  <= w_mem_addr_nxt;
            r_mem_wdata <= w_mem_wdata_nxt;
            r_if_rdata  <= w_if_rdata_nxt;
            r_if_valid  <= w_if_valid_nxt;
            r_dm_rdata  <= w_dm_rdata_nxt;
            r_dm_valid  <= w_dm_valid_nxt;
        end
    end

    assign mem_en    = r_mem_en;
    assign mem_we    = r_mem_we;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;
    assign if_rdata  = r_if_rdata;
    assign if_valid  = r_if_valid;
    assign dm_rdata  = r_dm_rdata;
    assign dm_valid  = r_dm_valid;
    assign if_stall  = if_req & ~r_if_valid;
    assign dm_stall  = dm_req & ~r_dm_valid;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench: expected completions are queued at request time and
// popped by a monitor whenever either requester sees its valid pulse.
module tb_mem_port_arbiter;

    logic        Clk, Reset;
    logic        if_req, if_flush, dm_req, dm_we;
    logic [31:0] if_addr, dm_addr, dm_wdata;
    logic        mem_en, mem_we, if_valid, dm_valid, if_stall, dm_stall;
    logic [31:0] mem_addr, mem_wdata, mem_rdata, if_rdata, dm_rdata;

    // second instance, LATENCY=1
    logic        b_if_req, b_if_flush, b_dm_req, b_dm_we;
    logic [31:0] b_if_addr, b_dm_addr, b_dm_wdata;
    logic        b_mem_en, b_mem_we, b_if_valid, b_dm_valid, b_if_stall, b_dm_stall;
    logic [31:0] b_mem_addr, b_mem_wdata, b_mem_rdata, b_if_rdata, b_dm_rdata;

    typedef struct packed {
        logic        is_dm;
        logic [31:0] data;
    } exp_t;

    exp_t        sb_q[$];
    exp_t        mon_e;
    int          n_total = 0;
    int          n_bad   = 0;

    logic [31:0] mem_model [256];
    logic        wr_v      [256];

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .LATENCY(2), .MAX_DM_STREAK(4)) dut (
        .Clk(Clk), .Reset(Reset), .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .if_rdata(if_rdata), .if_valid(if_valid),
        .dm_rdata(dm_rdata), .dm_valid(dm_valid), .if_stall(if_stall), .dm_stall(dm_stall)
    );

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .LATENCY(1), .MAX_DM_STREAK(4)) dut_l1 (
        .Clk(Clk), .Reset(Reset), .if_req(b_if_req), .if_addr(b_if_addr),
        .if_flush(b_if_flush), .dm_req(b_dm_req), .dm_we(b_dm_we), .dm_addr(b_dm_addr),
        .dm_wdata(b_dm_wdata), .mem_en(b_mem_en), .mem_we(b_mem_we),
        .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata), .mem_rdata(b_mem_rdata),
        .if_rdata(b_if_rdata), .if_valid(b_if_valid), .dm_rdata(b_dm_rdata),
        .dm_valid(b_dm_valid), .if_stall(b_if_stall), .dm_stall(b_dm_stall)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    function automatic logic [31:0] init_word(input logic [31:0] a);
        case (a)
            32'h10:  return 32'h2002000A;
            32'h14:  return 32'h11111111;
            32'h100: return 32'hF00D0001;
            32'h200: return 32'hDA7A0002;
            default: return a ^ 32'h5A5A0000;
        endcase
    endfunction

    assign mem_rdata   = wr_v[mem_addr[9:2]] ? mem_model[mem_addr[9:2]] : init_word(mem_addr);
    assign b_mem_rdata = b_mem_addr ^ 32'hA5A50000;

    always @(posedge Clk) begin
        if (Reset) begin
            for (int i = 0; i < 256; i++) wr_v[i] <= 1'b0;
        end else if (mem_en && mem_we) begin
            mem_model[mem_addr[9:2]] <= mem_wdata;
            wr_v[mem_addr[9:2]]      <= 1'b1;
        end
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic push(input logic is_dm, input logic [31:0] data);
        exp_t e;
        e.is_dm = is_dm;
        e.data  = data;
        sb_q.push_back(e);
    endtask

    // Monitor: every valid pulse must match the head of the scoreboard.
    always @(negedge Clk) begin
        chk("one_valid", 64'(if_valid & dm_valid), 64'd0);
        if (if_valid || dm_valid) begin
            chk("sb_nonempty", 64'(sb_q.size() != 0), 64'd1);
            if (sb_q.size() != 0) begin
                mon_e = sb_q.pop_front();
                chk("kind", 64'(dm_valid), 64'(mon_e.is_dm));
                if (dm_valid) chk("dm_rdata", 64'(dm_rdata), 64'(mon_e.data));
                else          chk("if_rdata", 64'(if_rdata), 64'(mon_e.data));
            end
        end
    end

    task automatic dm_wait(input logic we);
        int n = 0;
        do begin
            @(negedge Clk);
            n++;
            if (mem_en) chk("mem_we", 64'(mem_we), 64'(we));
        end while (!dm_valid && n < 40);
        chk("dm_done", 64'(dm_valid), 64'd1);
        dm_req = 1'b0;
        dm_we  = 1'b0;
    endtask

    task automatic dm_access(input logic we, input logic [31:0] a, input logic [31:0] wd,
                             input logic [31:0] exp_rd);
        push(1'b1, exp_rd);
        dm_req   = 1'b1;
        dm_we    = we;
        dm_addr  = a;
        dm_wdata = wd;
        dm_wait(we);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n;
        Reset = 1'b1;
        {if_req, if_flush, dm_req, dm_we} = '0;
        {if_addr, dm_addr, dm_wdata} = '0;
        {b_if_req, b_if_flush, b_dm_req, b_dm_we} = '0;
        {b_if_addr, b_dm_addr, b_dm_wdata} = '0;
        repeat (3) @(negedge Clk);
        chk("rst_ctl", 64'({mem_en, mem_we, if_valid, dm_valid}), 64'd0);
        chk("rst_addr", 64'(mem_addr), 64'd0);
        chk("rst_rdata", {if_rdata, dm_rdata}, 64'd0);
        chk("rst_stall", 64'({if_stall, dm_stall}), 64'd0);
        Reset = 1'b0;
        @(negedge Clk);

        // single fetch: cycle 0 request, mem_en 1..2, valid in 3
        if_req  = 1'b1;
        if_addr = 32'h10;
        push(1'b0, 32'h2002000A);
        #1;
        chk("f_stall_c0", 64'(if_stall), 64'd1);
        chk("f_en_c0", 64'(mem_en), 64'd0);
        for (int c = 1; c <= 2; c++) begin
            @(negedge Clk);
            chk("f_en", 64'(mem_en), 64'd1);
            chk("f_addr", 64'(mem_addr), 64'h10);
            chk("f_we", 64'(mem_we), 64'd0);
            chk("f_stall", 64'(if_stall), 64'd1);
        end
        @(negedge Clk);
        chk("f_valid_c3", 64'(if_valid), 64'd1);
        chk("f_stall_c3", 64'(if_stall), 64'd0);
        chk("f_en_c3", 64'(mem_en), 64'd0);
        if_req = 1'b0;

        // store then load; dm_rdata stays 0 across the store
        dm_access(1'b1, 32'h40, 32'hDEADBEEF, 32'h0);
        dm_access(1'b0, 32'h40, 32'h0, 32'hDEADBEEF);

        // flush in IDLE blocks the fetch grant
        if_req   = 1'b1;
        if_addr  = 32'h14;
        if_flush = 1'b1;
        repeat (3) begin
            @(negedge Clk);
            chk("idle_flush_en", 64'(mem_en), 64'd0);
        end
        if_req   = 1'b0;
        if_flush = 1'b0;
        @(negedge Clk);

        // flush during BUSY_IF in cycle 2
        if_req  = 1'b1;
        if_addr = 32'h14;
        @(negedge Clk);
        chk("fl_en_c1", 64'(mem_en), 64'd1);
        @(negedge Clk);
        chk("fl_en_c2", 64'(mem_en), 64'd1);
        if_flush = 1'b1;
        if_req   = 1'b0;
        @(negedge Clk);
        chk("fl_no_valid", 64'(if_valid), 64'd0);
        chk("fl_rdata_kept", 64'(if_rdata), 64'h2002000A);
        chk("fl_en_c3", 64'(mem_en), 64'd0);
        if_flush = 1'b0;
        push(1'b1, 32'hDEADBEEF);
        dm_req  = 1'b1;
        dm_we   = 1'b0;
        dm_addr = 32'h40;
        @(negedge Clk);
        chk("fl_regrant_en", 64'(mem_en), 64'd1);
        chk("fl_regrant_addr", 64'(mem_addr), 64'h40);
        dm_wait(1'b0);

        // contention: D,D,D,D,F,D,D,D,D,F
        for (int r = 0; r < 2; r++) begin
            for (int k = 0; k < 4; k++) push(1'b1, 32'hDA7A0002);
            push(1'b0, 32'hF00D0001);
        end
        if_req  = 1'b1;
        if_addr = 32'h100;
        dm_req  = 1'b1;
        dm_we   = 1'b0;
        dm_addr = 32'h200;
        n = 0;
        for (int cyc = 0; cyc < 200 && n < 10; cyc++) begin
            @(negedge Clk);
            if (if_valid || dm_valid) n++;
        end
        chk("cont_count", 64'(n), 64'd10);
        if_req = 1'b0;
        dm_req = 1'b0;
        @(negedge Clk);

        // reset in cycle 1 of a load
        dm_req  = 1'b1;
        dm_we   = 1'b0;
        dm_addr = 32'h200;
        @(negedge Clk);
        chk("rm_en_c1", 64'(mem_en), 64'd1);
        Reset = 1'b1;
        @(negedge Clk);
        chk("rm_ctl", 64'({mem_en, mem_we, if_valid, dm_valid}), 64'd0);
        chk("rm_addr", {mem_addr, mem_wdata}, 64'd0);
        chk("rm_rdata", {if_rdata, dm_rdata}, 64'd0);
        Reset  = 1'b0;
        dm_req = 1'b0;
        repeat (4) begin
            @(negedge Clk);
            chk("rm_no_valid", 64'(dm_valid), 64'd0);
        end
        dm_access(1'b0, 32'h200, 32'h0, 32'hDA7A0002);

        // LATENCY=1 back-to-back loads
        b_dm_req  = 1'b1;
        b_dm_addr = 32'h8;
        for (int c = 1; c <= 6; c++) begin
            @(negedge Clk);
            chk("l1_en", 64'(b_mem_en), 64'(c % 2 == 1));
            chk("l1_valid", 64'(b_dm_valid), 64'(c % 2 == 0));
            if (c % 2 == 0) chk("l1_rdata", 64'(b_dm_rdata), 64'hA5A50008);
        end
        b_dm_req = 1'b0;

        repeat (5) @(negedge Clk);
        chk("sb_drain", 64'(sb_q.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-port unified memory between the fetch stage (instruction reads) and the data-memory stage (loads/stores).
- Arbitrates between the two requesters and sequences each fixed-latency memory access with an FSM.
- Generates per-requester stall signals that feed PCWrite/pipeline-write gating.
- Data side has priority; a streak limiter guarantees fetch forward progress.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width.
- LATENCY, 2, memory access cycles (legal range 1..15).
- MAX_DM_STREAK, 4, max consecutive data grants while fetch waits (legal range 1..15).

Ports:
- Clk  input  1  clock; all state updates on rising edge.
- Reset  input  1  synchronous, active-high reset.
- if_req  input  1  fetch request; held high until if_valid.
- if_addr  input  ADDR_W  fetch address.
- if_flush  input  1  discard the in-flight or pending fetch (branch/jump taken).
- dm_req  input  1  data request; held high until dm_valid.
- dm_we  input  1  1 = store, 0 = load.
- dm_addr  input  ADDR_W  data address.
- dm_wdata  input  DATA_W  store data.
- mem_en  output  1  memory access active.
- mem_we  output  1  memory write enable.
- mem_addr  output  ADDR_W  memory address.
- mem_wdata  output  DATA_W  memory write data.
- mem_rdata  input  DATA_W  memory read data; valid in the last busy cycle.
- if_rdata  output  DATA_W  fetched instruction.
- if_valid  output  1  one-cycle completion pulse for fetch.
- dm_rdata  output  DATA_W  load data.
- dm_valid  output  1  one-cycle completion pulse for data (loads and stores).
- if_stall  output  1  if_req & ~if_valid (combinational).
- dm_stall  output  1  dm_req & ~dm_valid (combinational).

Behaviour:
- Reset values: state=IDLE, cnt=0, streak=0. All registered outputs 0: mem_en, mem_we, mem_addr, mem_wdata, if_rdata, if_valid, dm_rdata, dm_valid. Flush-pending flag cleared.
- FSM states: IDLE, BUSY_IF, BUSY_DM.
- IDLE arbitration, evaluated each edge:
  - dm_req and (~if_req or streak<MAX_DM_STREAK): grant data.
  - else if_req and ~if_flush: grant fetch.
  - else: stay in IDLE.
- Grant actions, registered at that edge:
  - Latch addr/wdata/we into mem_addr/mem_wdata/mem_we; mem_we=0 for fetch.
  - mem_en=1, cnt=LATENCY-1.
  - Go to BUSY_DM or BUSY_IF.
- Streak counter:
  - Data grant with if_req high: streak+1, saturating.
  - Data grant with if_req low: streak=0.
  - Fetch grant: streak=0.
- BUSY_x with cnt>0: cnt-1; memory outputs held stable. Requester inputs are ignored (already latched).
- BUSY_x with cnt==0, at the edge:
  - mem_en=0, mem_we=0; state=IDLE.
  - x_valid=1 for exactly one cycle.
  - Load/fetch: x_rdata <= mem_rdata.
  - Store: dm_rdata unchanged.
- Latency: request first seen in IDLE at cycle T gives mem_en high for cycles T+1..T+LATENCY and x_valid high in cycle T+LATENCY+1.
- Back-to-back: the valid cycle is an IDLE cycle, so a new grant can occur in it. Throughput is one access per LATENCY+1 cycles.
- if_rdata/dm_rdata hold their value until the next completion of the same requester.
- if_flush:
  - In IDLE: blocks the fetch grant that cycle.
  - During BUSY_IF: sets the flush-pending flag. The access still completes on memory (no abort), but if_valid is suppressed and if_rdata is not updated. Flag clears on return to IDLE.
  - Requester must drop or re-issue if_req after a flush.
- Simultaneous events:
  - Both requests in IDLE: data wins unless the streak limit is reached.
  - if_valid and dm_valid are never both high.
- Reset mid-access: next edge forces IDLE and mem_en=0; the pending result is lost with no valid pulse.
- Address widths pass through unmodified; no alignment checking.

Test Plan:
- Single fetch, LATENCY=2: if_req=1, if_addr=0x10 in cycle 0, mem model returns 0x2002000A. Expect mem_en cycles 1–2 with mem_addr=0x10, if_valid in cycle 3 with if_rdata=0x2002000A, if_stall high in cycles 0–2.
- Store then load: dm_we=1, addr=0x40, wdata=0xDEADBEEF; then load 0x40. Expect mem_we=1 only during the store, dm_valid pulse for each access, load returns 0xDEADBEEF, dm_rdata unchanged after the store.
- Contention: if_req and dm_req held high continuously with MAX_DM_STREAK=4. Expect grant order D,D,D,D,F,D,D,D,D,F…; fetch never waits more than 4 data accesses.
- Flush during BUSY_IF: assert if_flush in cycle 2 of a fetch. Expect mem_en through cycle 2, no if_valid, if_rdata unchanged, next grant possible in cycle 3.
- Reset mid-access: Reset=1 in cycle 1 of a data load. Expect all outputs 0 after the edge, no dm_valid, streak=0, and a fresh request then completes normally.
- LATENCY=1 back-to-back loads with dm_req held high: dm_valid in cycles 2, 4, 6; mem_en high in cycles 1, 3, 5.
